// File: rtl/flunky_apb_arb.sv
// Two-requester arbiter driving a single APB master port toward the flunky register slave.
// Define FLUNKY_ARB_ROUND_ROBIN_EN for alternating tie-break; otherwise requester 0 always wins ties.
module flunky_apb_arb #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  write0,
    input  logic                  write1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  busy,
    output logic                  grant
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0] state;
    logic       winner;

`ifdef FLUNKY_ARB_ROUND_ROBIN_EN
    // Requester that wins the next tie; flips to the loser after every grant.
    logic rr_pref;

    always_comb begin
        if (req0 && req1) begin
            winner = rr_pref;
        end else begin
            winner = req1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_pref <= 1'b0;
        end else if (state == ST_IDLE && (req0 || req1)) begin
            rr_pref <= ~winner;
        end
    end
`else
    always_comb begin
        winner = ~req0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            grant  <= 1'b0;
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state  <= ST_SETUP;
                        grant  <= winner;
                        paddr  <= winner ? addr1  : addr0;
                        pwrite <= winner ? write1 : write0;
                        pwdata <= winner ? wdata1 : wdata0;
                    end
                end
                ST_SETUP:  state <= ST_ACCESS;
                ST_ACCESS: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Bus strobes decode straight from state so an async reset drops them in the same cycle.
    always_comb begin
        psel    = (state == ST_SETUP) || (state == ST_ACCESS);
        penable = (state == ST_ACCESS);
        busy    = psel;
        ack0    = (state == ST_ACCESS) && !grant;
        ack1    = (state == ST_ACCESS) && grant;
        rdata   = (state == ST_ACCESS) ? prdata : '0;
    end

endmodule

// File: tb/tb_flunky_apb_arb.sv
// Self-checking bench for flunky_apb_arb: directed scenarios then random traffic against a transfer-timing model.
module tb_flunky_apb_arb;

    localparam int AW = 16;
    localparam int DW = 32;
`ifdef FLUNKY_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, write0, write1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] paddr;
    logic          pwrite, psel, penable;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          busy, grant;

    flunky_apb_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(rst),
        .req0(req0), .req1(req1), .write0(write0), .write1(write1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .prdata(prdata), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transfer-level model: a granted transfer occupies cycles setup_cyc and ack_cyc,
    // and the next request may only be taken at next_free or later.
    int            cyc;
    int            setup_cyc, ack_cyc, next_free;
    logic          m_win, m_last, m_grant, m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            rand_pd, rand_req, hold;
    logic          ord_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        setup_cyc = -10;
        ack_cyc   = -10;
        next_free = 0;
        m_last    = 1'b1;
        m_win     = 1'b0;
        m_grant   = 1'b0;
        m_write   = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
    endtask

    task automatic check_outputs();
        logic in_acc;
        in_acc = (cyc == ack_cyc);
        chk("psel",    psel,    (cyc == setup_cyc) || in_acc);
        chk("penable", penable, in_acc);
        chk("busy",    busy,    (cyc == setup_cyc) || in_acc);
        chk("ack0",    ack0,    in_acc && !m_win);
        chk("ack1",    ack1,    in_acc && m_win);
        chk("rdata",   rdata,   in_acc ? prdata : '0);
        chk("grant",   grant,   m_grant);
        chk("paddr",   paddr,   m_addr);
        chk("pwrite",  pwrite,  m_write);
        chk("pwdata",  pwdata,  m_wdata);
        if (ack0) ord_q.push_back(1'b0);
        if (ack1) ord_q.push_back(1'b1);
        $display("[TB] cyc %0d req=%b%b psel=%b pen=%b ack=%b%b grant=%b paddr=%h", cyc, req1, req0, psel, penable, ack1, ack0, grant, paddr);
    endtask

    task automatic tick();
        logic w;
        if (!rst && cyc >= next_free && (req0 || req1)) begin
            if (req0 && req1) w = RR_EN ? ~m_last : 1'b0;
            else              w = req1;
            m_win     = w;
            m_last    = w;
            m_grant   = w;
            m_addr    = w ? addr1  : addr0;
            m_write   = w ? write1 : write0;
            m_wdata   = w ? wdata1 : wdata0;
            setup_cyc = cyc + 1;
            ack_cyc   = cyc + 2;
            next_free = cyc + 3;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (rand_pd) prdata = $urandom;
        #1;
        check_outputs();
    endtask

    // Requester behaviour: drop req on the acked cycle, optionally raise new random requests.
    task automatic service();
        logic done0, done1;
        done0 = (cyc == ack_cyc) && !m_win;
        done1 = (cyc == ack_cyc) && m_win;
        if (!hold && done0) req0 = 1'b0;
        if (!hold && done1) req1 = 1'b0;
        if (rand_req) begin
            if (!req0 && !done0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; write0 = $urandom; addr0 = $urandom; wdata0 = $urandom;
            end
            if (!req1 && !done1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; write1 = $urandom; addr1 = $urandom; wdata1 = $urandom;
            end
        end
    endtask

    initial begin
        cyc = 0; rst = 1'b1;
        req0 = 0; req1 = 0; write0 = 0; write1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        prdata = '0; rand_pd = 0; rand_req = 0; hold = 0;
        model_reset();

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Single read from requester 0
        prdata = 32'hA5A5_0001;
        req0 = 1; addr0 = 16'h0004; write0 = 0; wdata0 = 32'h1234_5678;
        tick(); service();
        tick(); service();
        chk("rd_ack0", ack0, 1'b1);
        chk("rd_rdata", rdata, 32'hA5A5_0001);
        tick(); service();

        // Single write from requester 1
        req1 = 1; addr1 = 16'h0008; write1 = 1; wdata1 = 32'h0000_000F;
        repeat (3) begin tick(); service(); end
        chk("wr_grant", grant, 1'b1);

        // Continuous contention for four transfers
        ord_q.delete();
        hold = 1; req0 = 1; req1 = 1; write0 = 0; write1 = 0;
        repeat (11) begin tick(); service(); end
        hold = 0; req0 = 0; req1 = 0;
        tick();
        chk("ord_len", ord_q.size(), 4);
        for (int i = 0; i < 4 && i < ord_q.size(); i++)
            chk($sformatf("ord%0d", i), ord_q[i], RR_EN ? 1'(i % 2) : 1'b0);

        // Late request during requester 0's SETUP
        req0 = 1; addr0 = 16'h0010;
        tick(); service();
        req1 = 1; addr1 = 16'h0020; wdata1 = 32'hDEAD_BEEF; write1 = 1;
        repeat (6) begin tick(); service(); end

        // Reset in ACCESS aborts the transfer immediately
        req0 = 1; addr0 = 16'h0030; write0 = 0;
        tick(); tick();
        chk("pre_rst_ack0", ack0, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_ack0", ack0, 1'b0);
        chk("rst_paddr", paddr, '0);
        model_reset();
        tick();
        rst = 1'b0;
        repeat (3) begin tick(); service(); end

        // Random traffic
        rand_pd = 1; rand_req = 1;
        repeat (400) begin tick(); service(); end
        rand_req = 0;
        repeat (12) begin tick(); service(); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
